// File: rtl/uv_context_buffer_pkg.sv
// Shared constants, state encoding and recon byte-index helpers for the U/V context buffer.
package uv_context_buffer_pkg;

  localparam logic [7:0] UV_TOP_EDGE  = 8'd127;
  localparam logic [7:0] UV_LEFT_EDGE = 8'd129;
  localparam int UV_BLK_BYTES = 128;
  localparam int UV_ROW_BYTES = 16;
  localparam int UV_LINE_W    = 128;
  localparam int UV_ROW7_LSB  = 8 * UV_ROW_BYTES * 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RDW      = 3'd2,
    ST_CTX      = 3'd3,
    ST_WAIT_UPD = 3'd4,
    ST_WR       = 3'd5
  } uv_state_t;

  // recon byte index of U pixel (r,c) and V pixel (r,c) inside the 8x16 byte block
  function automatic int recon_u_idx(input int r, input int c);
    return r * UV_ROW_BYTES + c;
  endfunction

  function automatic int recon_v_idx(input int r, input int c);
    return r * UV_ROW_BYTES + 8 + c;
  endfunction

endpackage

// File: rtl/uv_context_buffer_if.sv
// Request/context/update bundle between the context buffer and its neighbours.
interface uv_context_buffer_if;
  logic          ctx_req;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          ctx_ready;
  logic          ctx_valid;
  logic [7:0]    top_left_u;
  logic [7:0]    top_left_v;
  logic [63:0]   top_u;
  logic [63:0]   top_v;
  logic [63:0]   left_u;
  logic [63:0]   left_v;
  logic          upd_valid;
  logic          upd_ready;
  logic [1023:0] recon;

  modport master (
    output ctx_req, x, y, upd_valid, recon,
    input  ctx_ready, ctx_valid, top_left_u, top_left_v, top_u, top_v,
           left_u, left_v, upd_ready
  );

  modport slave (
    input  ctx_req, x, y, upd_valid, recon,
    output ctx_ready, ctx_valid, top_left_u, top_left_v, top_u, top_v,
           left_u, left_v, upd_ready
  );
endinterface

// File: rtl/uv_context_buffer_line_ram.sv
// Simple dual-port line RAM holding the bottom U/V row of each MB column; registered read.
module uv_line_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uv_context_buffer.sv
// Per-MB U/V prediction context (top row, left column, top-left) from previously reconstructed MBs.
//
//  state       | meaning
//  ------------+-------------------------------------------------
//  ST_IDLE     | ready for a request, latches x/y on ctx_req
//  ST_RD       | line RAM read of column x issued
//  ST_RDW      | RAM data returns, context registers load
//  ST_CTX      | ctx_valid pulse, context outputs valid
//  ST_WAIT_UPD | waiting for reconstructed MB (upd_valid)
//  ST_WR       | bottom row to RAM[x], right column to left regs
module uv_context_buffer
  import uv_context_buffer_pkg::*;
#(
  parameter int MAX_MB_W = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  uv_context_buffer_if.slave bus,
  output logic               busy
);

  uv_state_t state_q, state_d;

  logic [9:0]           x_q, y_q;
  logic                 ram_re, ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [UV_LINE_W-1:0] ram_rdata, ram_wdata;

  logic [63:0] top_u_q, top_v_q, left_u_q, left_v_q;
  logic [7:0]  tl_u_q, tl_v_q;
  logic [63:0] prev_right_u_q, prev_right_v_q;
  logic [7:0]  saved_tl_u_q, saved_tl_v_q;

  logic [63:0] top_u_d, top_v_d, left_u_d, left_v_d;
  logic [7:0]  tl_u_d, tl_v_d;
  logic [63:0] right_u_recon, right_v_recon;
  logic        ctx_ready, upd_ready;
  logic        recon_unused;

  assign ram_addr     = ADDR_W'(x_q);
  assign ram_wdata    = bus.recon[UV_ROW7_LSB +: UV_LINE_W];
  assign recon_unused = ^bus.recon;

  uv_line_ram #(
    .DEPTH  (MAX_MB_W),
    .ADDR_W (ADDR_W),
    .DATA_W (UV_LINE_W)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_addr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ctx_ready = 1'b0;
    upd_ready = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ctx_ready = 1'b1;
        if (bus.ctx_req) state_d = ST_RD;
      end
      ST_RD: begin
        ram_re  = 1'b1;
        state_d = ST_RDW;
      end
      ST_RDW:  state_d = ST_CTX;
      ST_CTX:  state_d = ST_WAIT_UPD;
      ST_WAIT_UPD: begin
        upd_ready = 1'b1;
        if (bus.upd_valid) state_d = ST_WR;
      end
      ST_WR: begin
        // a reset landing on the WR edge aborts the write
        ram_we  = rst_n;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Right column of the reconstructed MB becomes the next MB's left context
  always_comb begin
    right_u_recon = '0;
    right_v_recon = '0;
    for (int j = 0; j < 8; j++) begin
      right_u_recon[8*j +: 8] = bus.recon[8*recon_u_idx(j, 7) +: 8];
      right_v_recon[8*j +: 8] = bus.recon[8*recon_v_idx(j, 7) +: 8];
    end
  end

  always_comb begin
    top_u_d  = (y_q == '0) ? {8{UV_TOP_EDGE}}  : ram_rdata[63:0];
    top_v_d  = (y_q == '0) ? {8{UV_TOP_EDGE}}  : ram_rdata[127:64];
    left_u_d = (x_q == '0) ? {8{UV_LEFT_EDGE}} : prev_right_u_q;
    left_v_d = (x_q == '0) ? {8{UV_LEFT_EDGE}} : prev_right_v_q;
    if (y_q == '0) begin
      tl_u_d = UV_TOP_EDGE;
      tl_v_d = UV_TOP_EDGE;
    end else if (x_q == '0) begin
      tl_u_d = UV_LEFT_EDGE;
      tl_v_d = UV_LEFT_EDGE;
    end else begin
      tl_u_d = saved_tl_u_q;
      tl_v_d = saved_tl_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q            <= '0;
      y_q            <= '0;
      top_u_q        <= '0;
      top_v_q        <= '0;
      left_u_q       <= '0;
      left_v_q       <= '0;
      tl_u_q         <= '0;
      tl_v_q         <= '0;
      prev_right_u_q <= '0;
      prev_right_v_q <= '0;
      saved_tl_u_q   <= '0;
      saved_tl_v_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.ctx_req) begin
        x_q <= bus.x;
        y_q <= bus.y;
      end
      // outputs and saved top-right land together so they are valid during CTX
      if (state_q == ST_RDW) begin
        top_u_q      <= top_u_d;
        top_v_q      <= top_v_d;
        left_u_q     <= left_u_d;
        left_v_q     <= left_v_d;
        tl_u_q       <= tl_u_d;
        tl_v_q       <= tl_v_d;
        saved_tl_u_q <= top_u_d[63:56];
        saved_tl_v_q <= top_v_d[63:56];
      end
      if (state_q == ST_WR) begin
        prev_right_u_q <= right_u_recon;
        prev_right_v_q <= right_v_recon;
      end
    end
  end

  assign bus.ctx_ready  = ctx_ready;
  assign bus.upd_ready  = upd_ready;
  assign bus.ctx_valid  = (state_q == ST_CTX);
  assign bus.top_u      = top_u_q;
  assign bus.top_v      = top_v_q;
  assign bus.left_u     = left_u_q;
  assign bus.left_v     = left_v_q;
  assign bus.top_left_u = tl_u_q;
  assign bus.top_left_v = tl_v_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uv_context_buffer.sv
// Self-checking bench for uv_context_buffer: pixel-level reference model plus hand-computed pins.
module tb_uv_context_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  uv_context_buffer_if bus();

  uv_context_buffer #(.MAX_MB_W(1024), .ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    int          due;
    logic [7:0]  tlu, tlv;
    logic [63:0] tu, tv, lu, lv;
  } ctx_t;

  ctx_t exp_q[$];
  ctx_t last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Reference model: bottom rows per column, right column of last MB, last emitted top byte 7
  logic [7:0] line_um [0:1023][0:7];
  logic [7:0] line_vm [0:1023][0:7];
  logic [7:0] left_um [0:7];
  logic [7:0] left_vm [0:7];
  logic [7:0] tl_um, tl_vm;
  logic [7:0] rc [0:127];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("ready_vs_busy", {63'd0, bus.ctx_ready}, {63'd0, ~busy});
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("ctx_valid_timeout", 64'd0, 64'd1);
        void'(exp_q.pop_front());
      end
      if (bus.ctx_valid) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          chk("unexpected_ctx_valid", 64'd1, 64'd0);
        end else begin
          last = exp_q.pop_front();
          chk("ctx_top_u", bus.top_u, last.tu);
          chk("ctx_top_v", bus.top_v, last.tv);
          chk("ctx_left_u", bus.left_u, last.lu);
          chk("ctx_left_v", bus.left_v, last.lv);
          chk("ctx_top_left_u", {56'd0, bus.top_left_u}, {56'd0, last.tlu});
          chk("ctx_top_left_v", {56'd0, bus.top_left_v}, {56'd0, last.tlv});
        end
      end else begin
        chk("hold_top_u", bus.top_u, last.tu);
        chk("hold_top_v", bus.top_v, last.tv);
        chk("hold_left_u", bus.left_u, last.lu);
        chk("hold_left_v", bus.left_v, last.lv);
        chk("hold_top_left", {48'd0, bus.top_left_u, bus.top_left_v}, {48'd0, last.tlu, last.tlv});
      end
    end
  end

  function automatic void set_rc(input int kind);
    for (int k = 0; k < 128; k++) begin
      case (kind)
        0:       rc[k] = 8'(k);
        1:       rc[k] = 8'(8'hA0 + k);
        2:       rc[k] = 8'hE0 | 8'(k & 15);
        default: rc[k] = 8'hFF;
      endcase
    end
  endfunction

  function automatic logic [1023:0] pack_rc();
    logic [1023:0] v;
    for (int k = 0; k < 128; k++) v[8*k +: 8] = rc[k];
    return v;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    last.tu = '0; last.tv = '0; last.lu = '0; last.lv = '0;
    last.tlu = '0; last.tlv = '0; last.due = 0;
    for (int j = 0; j < 8; j++) begin
      left_um[j] = '0;
      left_vm[j] = '0;
    end
    tl_um = '0;
    tl_vm = '0;
  endfunction

  task automatic wait_sig(input bit upd, input string name);
    int n = 0;
    @(negedge clk); #1;
    while (((upd ? bus.upd_ready : bus.ctx_ready) !== 1'b1) && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL %s: wait timed out after %0d cycles", name, n);
    end
  endtask

  task automatic req(input int xx, input int yy, input bit hold, input bit junk);
    ctx_t e;
    wait_sig(1'b0, "wait_ctx_ready");
    for (int i = 0; i < 8; i++) begin
      e.tu[8*i +: 8] = (yy == 0) ? 8'd127 : line_um[xx][i];
      e.tv[8*i +: 8] = (yy == 0) ? 8'd127 : line_vm[xx][i];
      e.lu[8*i +: 8] = (xx == 0) ? 8'd129 : left_um[i];
      e.lv[8*i +: 8] = (xx == 0) ? 8'd129 : left_vm[i];
    end
    e.tlu = (yy == 0) ? 8'd127 : (xx == 0) ? 8'd129 : tl_um;
    e.tlv = (yy == 0) ? 8'd127 : (xx == 0) ? 8'd129 : tl_vm;
    tl_um = e.tu[63:56];
    tl_vm = e.tv[63:56];
    // context is due in the third cycle after the accepting edge
    e.due = cyc + 3;
    exp_q.push_back(e);
    bus.ctx_req = 1'b1;
    bus.x = 10'(xx);
    bus.y = 10'(yy);
    if (junk) begin
      bus.upd_valid = 1'b1;
      bus.recon = '1;
    end
    @(posedge clk); #1;
    if (!hold) bus.ctx_req = 1'b0;
    bus.upd_valid = 1'b0;
    wait_sig(1'b1, "wait_upd_ready");
  endtask

  task automatic upd(input int xx, input int kind);
    set_rc(kind);
    bus.recon = pack_rc();
    bus.upd_valid = 1'b1;
    bus.ctx_req = 1'b0;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      line_um[xx][c] = rc[7*16 + c];
      line_vm[xx][c] = rc[7*16 + 8 + c];
    end
    for (int j = 0; j < 8; j++) begin
      left_um[j] = rc[j*16 + 7];
      left_vm[j] = rc[j*16 + 15];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ctx_req = 1'b0;
    bus.upd_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.recon = '0;
    rst_n = 1'b0;
    model_clear();
    for (int c = 0; c < 1024; c++)
      for (int i = 0; i < 8; i++) begin
        line_um[c][i] = '0;
        line_vm[c][i] = '0;
      end
    repeat (3) @(posedge clk);
    started = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ctx_ready", {63'd0, bus.ctx_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_upd_ready", {63'd0, bus.upd_ready}, 64'd0);
    chk("rst_ctx_valid", {63'd0, bus.ctx_valid}, 64'd0);
    chk("rst_top_u", bus.top_u, 64'd0);

    // T1: first MB of the picture
    req(0, 0, 1'b0, 1'b0);
    chk("t1_top_u", bus.top_u, 64'h7F7F7F7F7F7F7F7F);
    chk("t1_left_v", bus.left_v, 64'h8181818181818181);
    chk("t1_top_left_u", {56'd0, bus.top_left_u}, 64'd127);
    upd(0, 0);

    // T2: left column from recon byte k = k
    req(1, 0, 1'b0, 1'b0);
    chk("t2_left_u", bus.left_u, 64'h7767574737271707);
    chk("t2_left_v", bus.left_v, 64'h7F6F5F4F3F2F1F0F);
    chk("t2_top_v", bus.top_v, 64'h7F7F7F7F7F7F7F7F);
    chk("t2_top_left_v", {56'd0, bus.top_left_v}, 64'd127);
    upd(1, 0);

    // T3: row 1 reads the line RAM; MB0 recon = A0 + k
    req(0, 0, 1'b0, 1'b0);
    upd(0, 1);
    req(1, 0, 1'b0, 1'b0);
    upd(1, 0);
    req(0, 1, 1'b0, 1'b0);
    chk("t3_top_u", bus.top_u, 64'h1716151413121110);
    chk("t3_top_v", bus.top_v, 64'h1F1E1D1C1B1A1918);
    chk("t3_left_u", bus.left_u, 64'h8181818181818181);
    chk("t3_top_left_u", {56'd0, bus.top_left_u}, 64'd129);
    upd(0, 0);
    req(1, 1, 1'b0, 1'b0);
    chk("t3b_top_left_u", {56'd0, bus.top_left_u}, 64'h17);
    chk("t3b_top_left_v", {56'd0, bus.top_left_v}, 64'h1F);
    chk("t3b_top_u", bus.top_u, 64'h7776757473727170);
    upd(1, 0);

    // T4: ctx_req held through the MB, then stray updates while idle
    req(2, 0, 1'b1, 1'b0);
    upd(2, 2);
    @(negedge clk); #1;
    bus.upd_valid = 1'b1;
    bus.recon = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t4_idle_upd_ready", {63'd0, bus.upd_ready}, 64'd0);
    end
    bus.upd_valid = 1'b0;
    req(2, 1, 1'b0, 1'b1);
    chk("t4_top_u", bus.top_u, 64'hE7E6E5E4E3E2E1E0);
    chk("t4_top_v", bus.top_v, 64'hEFEEEDECEBEAE9E8);
    upd(2, 0);

    // T5: reset while waiting for the update
    req(2, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_ctx_ready", {63'd0, bus.ctx_ready}, 64'd1);
    chk("t5_left_u", bus.left_u, 64'd0);
    chk("t5_top_left", {48'd0, bus.top_left_u, bus.top_left_v}, 64'd0);
    req(0, 0, 1'b0, 1'b0);
    chk("t5_t1_top_v", bus.top_v, 64'h7F7F7F7F7F7F7F7F);
    chk("t5_t1_left_u", bus.left_u, 64'h8181818181818181);
    upd(0, 0);

    // T6: last RAM address, no wrap into column 0
    req(1023, 0, 1'b0, 1'b0);
    upd(1023, 2);
    req(1023, 1, 1'b0, 1'b0);
    chk("t6_top_u", bus.top_u, 64'hE7E6E5E4E3E2E1E0);
    chk("t6_top_left_u", {56'd0, bus.top_left_u}, 64'd127);
    upd(1023, 0);
    req(0, 1, 1'b0, 1'b0);
    chk("t6_col0_top_u", bus.top_u, 64'h7776757473727170);
    upd(0, 0);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
